stage_sequencer: RTL
====================

# stage_sequencer

Multi-cycle pipeline controller for the RV32IM core. It sequences the fetch, decode, exec, mem and write stages one instruction at a time using the stages' enabled/completed handshake, and skips the mem stage for non-memory instructions. It also counts retired instructions, handles halt requests and, optionally, detects a stage that never completes. It sits at the core top level, between the start/halt control and the five stage modules.

## Interface
Parameters:
- WDT_CYCLES, default 1024: maximum number of WAIT-state cycles allowed per stage before a fault. Only used when SEQ_WATCHDOG_EN is defined. Legal range is ≥ 2.

Ports:
- clk  in  1  core clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  begin or resume execution; level-sampled.
- halt_req  in  1  request to stop after the current instruction retires.
- is_mem  in  1  decoded instr is load or store; sampled in the cycle decode_completed is seen.
- fetch_enabled / decode_enabled / exec_enabled / mem_enabled / write_enabled  out  1 each  one-cycle start pulse to the stage.
- fetch_completed / decode_completed / exec_completed / mem_completed / write_completed  in  1 each  stage done (stage holds it high until its next enable).
- pc_update  out  1  one-cycle pulse when an instruction retires; the fetch stage latches the next pc on it.
- busy  out  1  high in any state except IDLE, HALTED and FAULT.
- halted  out  1  high in HALTED.
- fault  out  1  high in FAULT.
- fault_stage  out  3  stage that timed out: 0 fetch, 1 decode, 2 exec, 3 mem, 4 write.
- retired  out  32  count of retired instructions.

## Operation
- All outputs are registered. Reset values: every *_enabled=0, pc_update=0, busy=0, halted=0, fault=0, fault_stage=0, retired=0; state=IDLE; internal halt_pending=0 and is_mem_q=0.
- States: IDLE, F_EN, F_WAIT, D_EN, D_WAIT, X_EN, X_WAIT, M_EN, M_WAIT, W_EN, W_WAIT, HALTED, FAULT.
- IDLE → F_EN when start=1.
- Each *_EN state lasts exactly one cycle:
  - it drives the matching *_enabled=1;
  - next state is the matching *_WAIT.
- In every *_WAIT state, when the stage's *_completed=1:
  - F_WAIT → D_EN.
  - D_WAIT → X_EN; is_mem is latched into is_mem_q.
  - X_WAIT → M_EN if is_mem_q=1, otherwise → W_EN.
  - M_WAIT → W_EN.
  - W_WAIT (retire): pulse pc_update, increment retired (wraps 0xFFFFFFFF → 0). Then → HALTED if halt_pending or halt_req, otherwise → F_EN.
- A completed input seen during a *_EN cycle is ignored. It is stale from the previous instruction.
- A completed input from a stage that is not currently being waited on is ignored.
- halt_req=1 in any busy cycle sets halt_pending. halt_pending clears on entry to HALTED.
- A halt request never aborts a stage in progress.
- HALTED → F_EN when start=1. halted drops in that same transition. retired is preserved.
- start while busy is ignored.
- FAULT is terminal; only rstn leaves it.
- Reset asserted mid-instruction: all state and outputs return to reset values immediately. No pulse completes after rstn falls.

## Timing
- With a stage that completes the cycle after its enable:
  - non-mem instruction: 8 cycles per instruction (2 per stage);
  - memory instruction: 10 cycles.
- First fetch_enabled is high the cycle after start is sampled high in IDLE.
- pc_update is high in the cycle after write_completed is sampled, aligned with the F_EN cycle (fetch_enabled=1) or the first HALTED cycle.
- retired is updated in that same cycle.
- Exactly one *_enabled is high in any cycle, or none.

## Configuration
- SEQ_WATCHDOG_EN defined:
  - a counter clears on entry to each *_WAIT and increments every WAIT cycle without completion;
  - if a stage has not completed by the WDT_CYCLES-th WAIT cycle, the next state is FAULT, with fault=1 and fault_stage set to that stage's code.
- SEQ_WATCHDOG_EN undefined:
  - no counter is built;
  - WAIT states wait indefinitely;
  - fault and fault_stage are tied to 0.

## Test plan
- Reset then start=1 with all stages answering after 1 cycle and is_mem=0: fetch_enabled high at cycles 1, 9 and 17; mem_enabled never high; retired=2 at cycle 17.
- is_mem=1 on the second instruction: mem_enabled pulses once; that instruction takes 10 cycles; retired increments once per instruction.
- halt_req pulsed for 1 cycle during X_WAIT: the current instruction retires (pc_update=1), halted=1, no further fetch_enabled. A later start=1 resumes with retired preserved.
- decode_completed held high through D_EN (stale): the sequencer stays in D_WAIT until a fresh completed. X_EN does not occur in the cycle after D_EN.
- SEQ_WATCHDOG_EN with WDT_CYCLES=16 and exec_completed held low: fault=1 and fault_stage=2, with no further *_enabled pulses. rstn low clears fault to 0 asynchronously.
- retired preloaded to 0xFFFFFFFF via a hierarchical force, then one retire: retired=0.

Source files
------------

// File: rtl/stage_sequencer_if.sv
// rtl/stage_sequencer_if.sv - stage enable/complete handshake bundle between sequencer and the five stages
interface stage_sequencer_if;
    logic fetch_enabled;
    logic decode_enabled;
    logic exec_enabled;
    logic mem_enabled;
    logic write_enabled;
    logic fetch_completed;
    logic decode_completed;
    logic exec_completed;
    logic mem_completed;
    logic write_completed;
    logic is_mem;
    logic pc_update;

    modport master (
        output fetch_enabled, decode_enabled, exec_enabled, mem_enabled, write_enabled,
        output pc_update,
        input  fetch_completed, decode_completed, exec_completed, mem_completed, write_completed,
        input  is_mem
    );

    modport slave (
        input  fetch_enabled, decode_enabled, exec_enabled, mem_enabled, write_enabled,
        input  pc_update,
        output fetch_completed, decode_completed, exec_completed, mem_completed, write_completed,
        output is_mem
    );
endinterface

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - one-instruction-at-a-time stage sequencer; optional stage watchdog via SEQ_WATCHDOG_EN
module stage_sequencer #(
    parameter int WDT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              halt_req,
    stage_sequencer_if.master stg,
    output logic              busy,
    output logic              halted,
    output logic              fault,
    output logic [2:0]        fault_stage,
    output logic [31:0]       retired
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_F_EN,
        S_F_WAIT,
        S_D_EN,
        S_D_WAIT,
        S_X_EN,
        S_X_WAIT,
        S_M_EN,
        S_M_WAIT,
        S_W_EN,
        S_W_WAIT,
        S_HALTED,
        S_FAULT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        halt_pending;
    logic        is_mem_q;
    logic        wdt_expired;
    logic        state_busy;
    logic        in_en;
    logic        in_wait;
    logic [2:0]  wait_code;

    logic        fetch_en_d;
    logic        decode_en_d;
    logic        exec_en_d;
    logic        mem_en_d;
    logic        write_en_d;
    logic        pc_update_d;
    logic        busy_d;
    logic        halted_d;
    logic [31:0] retired_d;

    // Classify the current state: busy/EN/WAIT and which stage a WAIT state belongs to
    always_comb begin
        state_busy = !(state inside {S_IDLE, S_HALTED, S_FAULT});
        in_en      = state inside {S_F_EN, S_D_EN, S_X_EN, S_M_EN, S_W_EN};
        in_wait    = state inside {S_F_WAIT, S_D_WAIT, S_X_WAIT, S_M_WAIT, S_W_WAIT};
        case (state)
            S_F_WAIT: wait_code = 3'd0;
            S_D_WAIT: wait_code = 3'd1;
            S_X_WAIT: wait_code = 3'd2;
            S_M_WAIT: wait_code = 3'd3;
            S_W_WAIT: wait_code = 3'd4;
            default:  wait_code = 3'd0;
        endcase
    end

`ifdef SEQ_WATCHDOG_EN
    localparam int CNT_W = $clog2(WDT_CYCLES);

    logic [CNT_W-1:0] wdt_cnt;

    // Per-stage wait counter: cleared in each EN cycle so it starts at 0 on WAIT entry
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wdt_cnt <= '0;
        end else if (in_en) begin
            wdt_cnt <= '0;
        end else if (in_wait) begin
            wdt_cnt <= wdt_cnt + 1'b1;
        end
    end

    // The WDT_CYCLES-th WAIT cycle without completion is the last one allowed
    assign wdt_expired = in_wait && (wdt_cnt == CNT_W'(WDT_CYCLES - 1));

    // Fault flag and the code of the stage that timed out, latched on FAULT entry
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fault       <= 1'b0;
            fault_stage <= 3'd0;
        end else begin
            fault <= (state_next == S_FAULT);
            if (state_next == S_FAULT && state != S_FAULT) begin
                fault_stage <= wait_code;
            end
        end
    end
`else
    logic unused_wdt_cfg;

    assign unused_wdt_cfg = (WDT_CYCLES < 2) ^ (|wait_code);
    assign wdt_expired    = 1'b0;
    assign fault          = 1'b0;
    assign fault_stage    = 3'd0;
`endif

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; completed inputs are only looked at in the matching WAIT state
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_F_EN;
            S_F_EN:   state_next = S_F_WAIT;
            S_F_WAIT: begin
                if (stg.fetch_completed)  state_next = S_D_EN;
                else if (wdt_expired)     state_next = S_FAULT;
            end
            S_D_EN:   state_next = S_D_WAIT;
            S_D_WAIT: begin
                if (stg.decode_completed) state_next = S_X_EN;
                else if (wdt_expired)     state_next = S_FAULT;
            end
            S_X_EN:   state_next = S_X_WAIT;
            S_X_WAIT: begin
                if (stg.exec_completed)   state_next = is_mem_q ? S_M_EN : S_W_EN;
                else if (wdt_expired)     state_next = S_FAULT;
            end
            S_M_EN:   state_next = S_M_WAIT;
            S_M_WAIT: begin
                if (stg.mem_completed)    state_next = S_W_EN;
                else if (wdt_expired)     state_next = S_FAULT;
            end
            S_W_EN:   state_next = S_W_WAIT;
            S_W_WAIT: begin
                if (stg.write_completed)  state_next = (halt_pending || halt_req) ? S_HALTED : S_F_EN;
                else if (wdt_expired)     state_next = S_FAULT;
            end
            S_HALTED: if (start) state_next = S_F_EN;
            S_FAULT:  state_next = S_FAULT;
            default:  state_next = S_IDLE;
        endcase
    end

    // Output values for the next cycle, derived from the next state so outputs can be registered
    always_comb begin
        fetch_en_d  = (state_next == S_F_EN);
        decode_en_d = (state_next == S_D_EN);
        exec_en_d   = (state_next == S_X_EN);
        mem_en_d    = (state_next == S_M_EN);
        write_en_d  = (state_next == S_W_EN);
        busy_d      = !(state_next inside {S_IDLE, S_HALTED, S_FAULT});
        halted_d    = (state_next == S_HALTED);
        pc_update_d = (state == S_W_WAIT) && stg.write_completed;
        retired_d   = pc_update_d ? retired + 32'd1 : retired;
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stg.fetch_enabled  <= 1'b0;
            stg.decode_enabled <= 1'b0;
            stg.exec_enabled   <= 1'b0;
            stg.mem_enabled    <= 1'b0;
            stg.write_enabled  <= 1'b0;
            stg.pc_update      <= 1'b0;
            busy               <= 1'b0;
            halted             <= 1'b0;
            retired            <= 32'd0;
        end else begin
            stg.fetch_enabled  <= fetch_en_d;
            stg.decode_enabled <= decode_en_d;
            stg.exec_enabled   <= exec_en_d;
            stg.mem_enabled    <= mem_en_d;
            stg.write_enabled  <= write_en_d;
            stg.pc_update      <= pc_update_d;
            busy               <= busy_d;
            halted             <= halted_d;
            retired            <= retired_d;
        end
    end

    // Halt request capture and is_mem latch taken when decode finishes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            halt_pending <= 1'b0;
            is_mem_q     <= 1'b0;
        end else begin
            if (state_next == S_HALTED) begin
                halt_pending <= 1'b0;
            end else if (halt_req && state_busy) begin
                halt_pending <= 1'b1;
            end
            if (state == S_D_WAIT && stg.decode_completed) begin
                is_mem_q <= stg.is_mem;
            end
        end
    end

endmodule
